// File: rtl/arb_pkg.sv
// Shared definitions for the 4-way round-robin arbiter: requester count,
// id width and the arbiter state encoding.
package arb_pkg;

  localparam int N_REQ = 4;
  localparam int ID_W  = 2;

  // IDLE: waiting to grant; BUSY: an owner holds the resource;
  // GAP: one-cycle bus turnaround after a grant ends.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    GAP  = 2'd2
  } arb_state_e;

endpackage

// File: rtl/onehot_enc4.sv
// Combinational 4-bit one-hot to 2-bit binary encoder.
// Both 4'b0001 and the all-zero vector encode to 2'b00.
module onehot_enc4
  import arb_pkg::*;
(
  input  logic [N_REQ-1:0] onehot,
  output logic [ID_W-1:0]  id
);

  // Each id bit is the OR of the one-hot positions that have that bit set.
  always_comb begin
    id = {onehot[3] | onehot[2], onehot[3] | onehot[1]};
  end

endmodule

// File: rtl/rr_arbiter4.sv
// Round-robin arbiter sharing one downstream resource between 4 requesters.
// An owner keeps the grant until it drops its request, or until it has held
// the grant for MAX_HOLD cycles while another requester is waiting. Every
// grant is followed by one GAP cycle and one IDLE cycle before the next.
//
// Handshake: req[i] is a level request held high while requester i wants
// the resource; gnt[i] high means requester i owns it this cycle. Dropping
// req[i] while owning releases the resource at the next clock edge.
module rr_arbiter4
  import arb_pkg::*;
#(
  parameter int MAX_HOLD = 16,
  parameter int CNT_W    = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] gnt,
  output logic [ID_W-1:0]  gnt_id,
  output logic             gnt_valid,
  output logic             timeout
);

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

  arb_state_e       state_q;
  logic [ID_W-1:0]  ptr_q;
  logic [CNT_W-1:0] hold_q;
  logic [N_REQ-1:0] sel;
  logic [ID_W-1:0]  sel_id;
  logic             owner_req;
  logic             others_req;

  // Rotating priority: scan ptr+1, ptr+2, ptr+3, then ptr itself; the 2-bit
  // index wraps naturally so the last step lands back on ptr.
  always_comb begin
    logic             found;
    logic [ID_W-1:0]  idx;
    sel   = '0;
    found = 1'b0;
    idx   = '0;
    for (int i = 1; i <= N_REQ; i++) begin
      idx = ptr_q + ID_W'(i);
      if (!found && req[idx]) begin
        sel[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end

  onehot_enc4 u_enc (
    .onehot (sel),
    .id     (sel_id)
  );

  // Owner still requesting, and whether anyone else is waiting behind it.
  always_comb begin
    owner_req  = |(req & gnt);
    others_req = |(req & ~gnt);
  end

  assign gnt_valid = |gnt;

  // Arbiter FSM: grant in IDLE, hold/release/preempt in BUSY, turnaround in GAP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      gnt     <= '0;
      gnt_id  <= '0;
      ptr_q   <= ID_W'(N_REQ - 1);
      hold_q  <= '0;
      timeout <= 1'b0;
    end else begin
      timeout <= 1'b0;
      case (state_q)
        IDLE: begin
          if (en && (|req)) begin
            gnt     <= sel;
            gnt_id  <= sel_id;
            ptr_q   <= sel_id;
            hold_q  <= '0;
            state_q <= BUSY;
          end
        end
        BUSY: begin
          if (!owner_req) begin
            // Release wins over preemption, so no timeout pulse here.
            gnt     <= '0;
            state_q <= GAP;
          end else if ((hold_q == HOLD_LAST) && others_req) begin
            gnt     <= '0;
            timeout <= 1'b1;
            state_q <= GAP;
          end else if (hold_q != HOLD_LAST) begin
            hold_q <= hold_q + CNT_W'(1);
          end
        end
        GAP: begin
          state_q <= IDLE;
        end
        default: begin
          gnt     <= '0;
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule
